// File: rtl/unidade_controle_timeout_pkg.sv
// rtl/unidade_controle_timeout_pkg.sv - shared state codes and defaults for the memory-game control unit
package unidade_controle_timeout_pkg;

    localparam int TIMEOUT_CICLOS_PADRAO = 3000;

    // Codes are fixed because the 7-segment debug display decodes them directly.
    typedef enum logic [3:0] {
        INICIAL        = 4'b0000,
        PREPARACAO     = 4'b0001,
        INICIO_RODADA  = 4'b0010,
        ESPERA_JOGADA  = 4'b0011,
        REGISTRA       = 4'b0100,
        COMPARACAO     = 4'b0101,
        PROXIMO        = 4'b0110,
        PROXIMA_RODADA = 4'b0111,
        FIM_GANHOU     = 4'b1010,
        FIM_TIMEOUT    = 4'b1101,
        FIM_PERDEU     = 4'b1110
    } estado_t;

endpackage

// File: rtl/unidade_controle_timeout_contador_timeout.sv
// rtl/unidade_controle_timeout_contador_timeout.sv - per-play inactivity timer, saturates at the last cycle
module contador_timeout #(
    parameter int TIMEOUT_CICLOS = 3000
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    localparam int W = $clog2(TIMEOUT_CICLOS);
    localparam logic [W-1:0] ULTIMO = W'(TIMEOUT_CICLOS - 1);

    logic [W-1:0] contagem;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            contagem <= '0;
        end else if (zera) begin
            contagem <= '0;
        end else if (conta && !fim) begin
            contagem <= contagem + W'(1);
        end
    end

    assign fim = (contagem == ULTIMO);

endmodule

// File: rtl/unidade_controle_timeout.sv
// rtl/unidade_controle_timeout.sv - Moore control FSM for the memory game with per-play timeout
module unidade_controle_timeout
    import unidade_controle_timeout_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       enderecoIgualRodada,
    input  logic       fimR,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraR,
    output logic       contaR,
    output logic       registraR,
    output logic       pronto,
    output logic       ganhou,
    output logic       perdeu,
    output logic       db_timeout,
    output logic [3:0] db_estado
);

    estado_t estado;
    estado_t proximo_estado;
    logic    espera;
    logic    fim_timeout;

    assign espera = (estado == ESPERA_JOGADA);

    // Timer is held at zero outside espera_jogada so every play gets a full window.
    contador_timeout #(
        .TIMEOUT_CICLOS(TIMEOUT_CICLOS)
    ) u_contador_timeout (
        .clock (clock),
        .reset (reset),
        .zera  (~espera),
        .conta (espera),
        .fim   (fim_timeout)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= INICIAL;
        end else begin
            estado <= proximo_estado;
        end
    end

    always_comb begin
        proximo_estado = INICIAL;
        case (estado)
            INICIAL:        proximo_estado = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:     proximo_estado = INICIO_RODADA;
            INICIO_RODADA:  proximo_estado = ESPERA_JOGADA;
            // A play arriving on the last timer cycle still counts.
            ESPERA_JOGADA: begin
                if (jogada)           proximo_estado = REGISTRA;
                else if (fim_timeout) proximo_estado = FIM_TIMEOUT;
                else                  proximo_estado = ESPERA_JOGADA;
            end
            REGISTRA:       proximo_estado = COMPARACAO;
            COMPARACAO: begin
                if (!igual)                             proximo_estado = FIM_PERDEU;
                else if (enderecoIgualRodada && fimR)   proximo_estado = FIM_GANHOU;
                else if (enderecoIgualRodada)           proximo_estado = PROXIMA_RODADA;
                else                                    proximo_estado = PROXIMO;
            end
            PROXIMO:        proximo_estado = ESPERA_JOGADA;
            PROXIMA_RODADA: proximo_estado = INICIO_RODADA;
            FIM_GANHOU:     proximo_estado = iniciar ? PREPARACAO : FIM_GANHOU;
            FIM_PERDEU:     proximo_estado = iniciar ? PREPARACAO : FIM_PERDEU;
            FIM_TIMEOUT:    proximo_estado = iniciar ? PREPARACAO : FIM_TIMEOUT;
            default:        proximo_estado = INICIAL;
        endcase
    end

    always_comb begin
        zeraE      = 1'b0;
        contaE     = 1'b0;
        zeraR      = 1'b0;
        contaR     = 1'b0;
        registraR  = 1'b0;
        pronto     = 1'b0;
        ganhou     = 1'b0;
        perdeu     = 1'b0;
        db_timeout = 1'b0;
        case (estado)
            PREPARACAO:     begin zeraE = 1'b1; zeraR = 1'b1; end
            INICIO_RODADA:  zeraE = 1'b1;
            REGISTRA:       registraR = 1'b1;
            PROXIMO:        contaE = 1'b1;
            PROXIMA_RODADA: contaR = 1'b1;
            FIM_GANHOU:     begin pronto = 1'b1; ganhou = 1'b1; end
            FIM_PERDEU:     begin pronto = 1'b1; perdeu = 1'b1; end
            FIM_TIMEOUT:    begin pronto = 1'b1; perdeu = 1'b1; db_timeout = 1'b1; end
            default:        ;
        endcase
    end

    assign db_estado = estado;

endmodule
